// File: rtl/bank_egress_arbiter.sv
// Bank egress arbiter: zero-latency local delivery, remote packets via 2-entry FIFO (push visible next cycle).
// Backpressure: req_ready gated by ingress claims, slot conflicts and FIFO space; stats behind ARB_STATS_EN.
module bank_egress_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PKT_W        = 64,
  parameter int STARVE_LIMIT = 15,
  parameter int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*PKT_W-1:0] req_pkt,
  input  logic [NUM_REQ-1:0]       req_local,
  input  logic [NUM_REQ*IDX_W-1:0] req_dest,
  input  logic [NUM_REQ-1:0]       ingress_claim,
  output logic [NUM_REQ-1:0]       local_valid,
  output logic [NUM_REQ*PKT_W-1:0] local_pkt,
  output logic                     router_valid_out,
  input  logic                     router_ready_out,
  output logic [PKT_W-1:0]         router_out_pkt,
  output logic [IDX_W-1:0]         rr_ptr_o
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]              stat_local_grants,
  output logic [31:0]              stat_remote_grants,
  output logic [31:0]              stat_conflicts,
  output logic [31:0]              stat_prio_entries
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {SCAN = 1'b0, PRIO = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] prio_idx_q, prio_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] scan_start;
  logic [CNT_W-1:0] wait_q [NUM_REQ];
  logic [CNT_W-1:0] wait_d [NUM_REQ];
  logic [PKT_W-1:0] mem_q [2];
  logic [PKT_W-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;

  logic               push, pop;
  logic [PKT_W-1:0]   push_dat;
  logic               any_grant;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   idx, dst;
  logic [NUM_REQ-1:0] slot_busy;
  logic               remote_done;
  logic               starve_any;
  logic [IDX_W-1:0]   starve_idx;
`ifdef ARB_STATS_EN
  logic [IDX_W:0]     n_local, n_conf;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      prio_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_idx_q <= prio_idx_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d    = state_q;
    prio_idx_d = prio_idx_q;
    case (state_q)
      SCAN: if (starve_any) begin
        state_d    = PRIO;
        prio_idx_d = starve_idx;
      end
      PRIO: if (req_ready[prio_idx_q] || !req_valid[prio_idx_q]) state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  // FSM output
  always_comb scan_start = (state_q == PRIO) ? prio_idx_q : rr_ptr_q;

  // Scan never stops early: a blocked requester must not hide later ones.
  always_comb begin
    req_ready   = '0;
    local_valid = '0;
    local_pkt   = '0;
    push        = 1'b0;
    push_dat    = '0;
    any_grant   = 1'b0;
    last_idx    = '0;
    idx         = '0;
    dst         = '0;
    slot_busy   = ingress_claim;
    remote_done = 1'b0;
`ifdef ARB_STATS_EN
    n_local     = '0;
    n_conf      = '0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = scan_start + IDX_W'(k);
      dst = req_dest[idx*IDX_W +: IDX_W];
      if (req_valid[idx]) begin
        if (req_local[idx]) begin
          if (!slot_busy[dst]) begin
            slot_busy[dst]                 = 1'b1;
            local_valid[dst]               = 1'b1;
            local_pkt[dst*PKT_W +: PKT_W]  = req_pkt[idx*PKT_W +: PKT_W];
            req_ready[idx]                 = 1'b1;
            any_grant                      = 1'b1;
            last_idx                       = idx;
`ifdef ARB_STATS_EN
            n_local                        = n_local + 1'b1;
`endif
          end else begin
`ifdef ARB_STATS_EN
            n_conf = n_conf + 1'b1;
`endif
          end
        end else if (!remote_done && cnt_q != 2'd2) begin
          remote_done    = 1'b1;
          push           = 1'b1;
          push_dat       = req_pkt[idx*PKT_W +: PKT_W];
          req_ready[idx] = 1'b1;
          any_grant      = 1'b1;
          last_idx       = idx;
        end
      end
    end
  end

  always_comb rr_ptr_d = any_grant ? last_idx + IDX_W'(1) : rr_ptr_q;
  assign rr_ptr_o = rr_ptr_q;

  always_comb begin
    starve_any = 1'b0;
    starve_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      wait_d[i] = '0;
      if (req_valid[i] && !req_ready[i])
        wait_d[i] = (wait_q[i] == CNT_W'(STARVE_LIMIT)) ? wait_q[i] : wait_q[i] + 1'b1;
      if (wait_q[i] == CNT_W'(STARVE_LIMIT)) begin
        starve_any = 1'b1;
        starve_idx = IDX_W'(i);
      end
    end
  end

  // Space is judged on the registered count, so push never meets a full FIFO.
  assign pop              = (cnt_q != 2'd0) && router_ready_out;
  assign router_valid_out = (cnt_q != 2'd0);
  assign router_out_pkt   = router_valid_out ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < 2; i++) mem_q[i] <= mem_d[i];
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] stat_local_grants_q, stat_local_grants_d;
  logic [31:0] stat_remote_grants_q, stat_remote_grants_d;
  logic [31:0] stat_conflicts_q, stat_conflicts_d;
  logic [31:0] stat_prio_entries_q, stat_prio_entries_d;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [IDX_W:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    stat_local_grants_d  = sat_add(stat_local_grants_q, n_local);
    stat_remote_grants_d = sat_add(stat_remote_grants_q, (IDX_W+1)'(push));
    stat_conflicts_d     = sat_add(stat_conflicts_q, n_conf);
    stat_prio_entries_d  = sat_add(stat_prio_entries_q,
                                   (IDX_W+1)'(state_q == SCAN && state_d == PRIO));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_local_grants_q  <= '0;
      stat_remote_grants_q <= '0;
      stat_conflicts_q     <= '0;
      stat_prio_entries_q  <= '0;
    end else begin
      stat_local_grants_q  <= stat_local_grants_d;
      stat_remote_grants_q <= stat_remote_grants_d;
      stat_conflicts_q     <= stat_conflicts_d;
      stat_prio_entries_q  <= stat_prio_entries_d;
    end
  end

  assign stat_local_grants  = stat_local_grants_q;
  assign stat_remote_grants = stat_remote_grants_q;
  assign stat_conflicts     = stat_conflicts_q;
  assign stat_prio_entries  = stat_prio_entries_q;
`endif

endmodule
